// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and sizes for the MEM pipeline stage
//
// Holds the stage FSM state type, the datapath word width and the maximum
// WOM burst length. The beat counter width is derived from the burst length.
package mem_pkg;

  localparam int WORD_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = $clog2(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/flopr.sv
// rtl/flopr.sv - resettable register, asynchronous active-high reset
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q
//   d    - next value, loaded every rising edge
//   q    - registered value
module flopr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with burst writes to write-only memory
//
// An instruction flagged wr_wom_in is captured in IDLE together with its base
// address and four data words; the stage then issues one WOM write (or four
// consecutive ones when wr_mul_pos_in is set) while stalling the pipe. Each
// beat is held until wom_ready accepts it. Write-back fields are registered
// with a one-cycle latency and turn into a bubble while a burst is running.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   wr_pxl_in/wr_pos_in/wr_mul_reg_in - write-back flags from EXE/MEM
//   wr_wom_in, wr_mul_pos_in  - WOM write request, four-beat select
//   i_in, j_in, n_in          - write-back data from EXE/MEM
//   wom_addr_in, r1_in..r4_in - WOM base address and burst data words
//   stall                     - holds EXE/MEM and earlier stages
//   wom_we, wom_addr, wom_wdata, wom_ready - WOM write handshake
//   wr_*_out, i/j/n_out, r1..r4_out       - registered write-back outputs
module mem_stage
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_pxl_in,
  input  logic              wr_pos_in,
  input  logic              wr_mul_reg_in,
  input  logic              wr_wom_in,
  input  logic              wr_mul_pos_in,
  input  logic [WORD_W-1:0] i_in,
  input  logic [WORD_W-1:0] j_in,
  input  logic [WORD_W-1:0] n_in,
  input  logic [WORD_W-1:0] wom_addr_in,
  input  logic [WORD_W-1:0] r1_in,
  input  logic [WORD_W-1:0] r2_in,
  input  logic [WORD_W-1:0] r3_in,
  input  logic [WORD_W-1:0] r4_in,
  output logic              stall,
  output logic              wom_we,
  output logic [WORD_W-1:0] wom_addr,
  output logic [WORD_W-1:0] wom_wdata,
  input  logic              wom_ready,
  output logic              wr_pxl_out,
  output logic              wr_pos_out,
  output logic              wr_mul_reg_out,
  output logic [WORD_W-1:0] i_out,
  output logic [WORD_W-1:0] j_out,
  output logic [WORD_W-1:0] n_out,
  output logic [WORD_W-1:0] r1_out,
  output logic [WORD_W-1:0] r2_out,
  output logic [WORD_W-1:0] r3_out,
  output logic [WORD_W-1:0] r4_out
);

  localparam int WB_DATA_W = 7 * WORD_W;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] last;
  logic [WORD_W-1:0] base;
  logic [WORD_W-1:0] r_lat [BURST_LEN];

  logic              capture;
  logic              advance;

  logic [2:0]           wb_flags_d;
  logic [WB_DATA_W-1:0] wb_data_d;
  logic [WB_DATA_W-1:0] wb_data_q;

  assign capture = (state == IDLE) && wr_wom_in;
  assign advance = (state == BURST) && wom_ready && (beat != last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // WOM outputs are decoded from state so that reset clears them at once.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    wom_we    = 1'b0;
    wom_addr  = '0;
    wom_wdata = '0;
    case (state)
      IDLE: begin
        if (wr_wom_in) state_nxt = BURST;
      end
      BURST: begin
        stall     = 1'b1;
        wom_we    = 1'b1;
        wom_addr  = base + WORD_W'(beat);
        wom_wdata = r_lat[beat];
        if (wom_ready && (beat == last)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
      last <= '0;
      base <= '0;
      for (int k = 0; k < BURST_LEN; k++) r_lat[k] <= '0;
    end else if (capture) begin
      beat     <= '0;
      last     <= wr_mul_pos_in ? BEAT_W'(BURST_LEN - 1) : '0;
      base     <= wom_addr_in;
      r_lat[0] <= r1_in;
      r_lat[1] <= r2_in;
      r_lat[2] <= r3_in;
      r_lat[3] <= r4_in;
    end else if (advance) begin
      beat <= beat + BEAT_W'(1);
    end
  end

  // While stalled the write-back flags become a bubble and the data is held,
  // so the instruction waiting upstream is only loaded once IDLE returns.
  assign wb_flags_d = stall ? 3'b000 : {wr_pxl_in, wr_pos_in, wr_mul_reg_in};
  assign wb_data_d  = stall ? wb_data_q
                            : {i_in, j_in, n_in, r1_in, r2_in, r3_in, r4_in};

  flopr #(.WIDTH(3)) u_wb_flags (
    .clk (clk),
    .rst (rst),
    .d   (wb_flags_d),
    .q   ({wr_pxl_out, wr_pos_out, wr_mul_reg_out})
  );

  flopr #(.WIDTH(WB_DATA_W)) u_wb_data (
    .clk (clk),
    .rst (rst),
    .d   (wb_data_d),
    .q   (wb_data_q)
  );

  assign {i_out, j_out, n_out, r1_out, r2_out, r3_out, r4_out} = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pxl_in, wr_pos_in, wr_mul_reg_in, wr_wom_in, wr_mul_pos_in;
  logic [31:0] i_in, j_in, n_in, wom_addr_in, r1_in, r2_in, r3_in, r4_in;
  logic        stall, wom_we, wom_ready;
  logic [31:0] wom_addr, wom_wdata;
  logic        wr_pxl_out, wr_pos_out, wr_mul_reg_out;
  logic [31:0] i_out, j_out, n_out, r1_out, r2_out, r3_out, r4_out;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .wr_pxl_in(wr_pxl_in), .wr_pos_in(wr_pos_in), .wr_mul_reg_in(wr_mul_reg_in),
    .wr_wom_in(wr_wom_in), .wr_mul_pos_in(wr_mul_pos_in),
    .i_in(i_in), .j_in(j_in), .n_in(n_in), .wom_addr_in(wom_addr_in),
    .r1_in(r1_in), .r2_in(r2_in), .r3_in(r3_in), .r4_in(r4_in),
    .stall(stall), .wom_we(wom_we), .wom_addr(wom_addr), .wom_wdata(wom_wdata),
    .wom_ready(wom_ready),
    .wr_pxl_out(wr_pxl_out), .wr_pos_out(wr_pos_out), .wr_mul_reg_out(wr_mul_reg_out),
    .i_out(i_out), .j_out(j_out), .n_out(n_out),
    .r1_out(r1_out), .r2_out(r2_out), .r3_out(r3_out), .r4_out(r4_out)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of WOM writes still owed plus the expected
  // write-back register contents.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t          pend_q[$];
  logic [2:0]   e_flags;
  logic [223:0] e_data;

  task automatic model_reset();
    pend_q.delete();
    e_flags = '0;
    e_data  = '0;
  endtask

  task automatic model_clock();
    wr_t         w;
    logic [31:0] rr [4];
    int          cnt;
    if (pend_q.size() != 0) begin
      if (wom_ready) w = pend_q.pop_front();
      e_flags = 3'b000;
    end else begin
      e_flags = {wr_pxl_in, wr_pos_in, wr_mul_reg_in};
      e_data  = {i_in, j_in, n_in, r1_in, r2_in, r3_in, r4_in};
      if (wr_wom_in) begin
        rr[0] = r1_in; rr[1] = r2_in; rr[2] = r3_in; rr[3] = r4_in;
        cnt = wr_mul_pos_in ? 4 : 1;
        for (int k = 0; k < cnt; k++) begin
          w.addr = wom_addr_in + 32'(k);
          w.data = rr[k];
          pend_q.push_back(w);
        end
      end
    end
  endtask

  function automatic logic exp_busy();
    return pend_q.size() != 0;
  endfunction

  function automatic logic [31:0] exp_addr();
    return (pend_q.size() != 0) ? pend_q[0].addr : 32'h0;
  endfunction

  function automatic logic [31:0] exp_data();
    return (pend_q.size() != 0) ? pend_q[0].data : 32'h0;
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    {wr_pxl_in, wr_pos_in, wr_mul_reg_in, wr_wom_in, wr_mul_pos_in} = '0;
    {i_in, j_in, n_in, wom_addr_in, r1_in, r2_in, r3_in, r4_in} = '0;
    wom_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {wr_pxl_in, wr_pos_in, wr_mul_reg_in, wr_wom_in, wr_mul_pos_in} = 5'b11111;
    i_in = $urandom; j_in = $urandom; n_in = $urandom; wom_addr_in = $urandom;
    r1_in = $urandom; r2_in = $urandom; r3_in = $urandom; r4_in = $urandom;
    wom_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({stall, wom_we, wom_addr, wom_wdata} !== 66'b0) begin
      n_err++;
      $display("FAIL reset_wom got %h want 0", {stall, wom_we, wom_addr, wom_wdata});
    end
    n_vec++;
    if ({wr_pxl_out, wr_pos_out, wr_mul_reg_out, i_out, j_out, n_out,
         r1_out, r2_out, r3_out, r4_out} !== 227'b0) begin
      n_err++;
      $display("FAIL reset_wb got %h want 0", {wr_pxl_out, wr_pos_out, wr_mul_reg_out, i_out});
    end
    model_reset();
    set_idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    wr_wom_in = 1'b1; wr_mul_pos_in = 1'b0; wom_addr_in = 32'h100;
    r1_in = 32'hAA; r2_in = $urandom; r3_in = $urandom; r4_in = $urandom;
    wom_ready = 1'b1;
    tick();
    wr_wom_in = 1'b0;
    n_vec++;
    if ({stall, wom_we, wom_addr, wom_wdata} !== {1'b1, 1'b1, 32'h100, 32'hAA}) begin
      n_err++;
      $display("FAIL single_write got s=%b we=%b a=%h d=%h want s=1 we=1 a=100 d=aa",
               stall, wom_we, wom_addr, wom_wdata);
    end
    tick();
    n_vec++;
    if ({stall, wom_we, wom_addr} !== 34'b0) begin
      n_err++;
      $display("FAIL single_end got s=%b we=%b a=%h want 0", stall, wom_we, wom_addr);
    end
  endtask

  task automatic test_burst(input logic [31:0] base);
    wr_wom_in = 1'b1; wr_mul_pos_in = 1'b1; wom_addr_in = base;
    r1_in = 32'd1; r2_in = 32'd2; r3_in = 32'd3; r4_in = 32'd4;
    wom_ready = 1'b1;
    tick();
    wr_wom_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({stall, wom_we, wom_addr, wom_wdata} !== {1'b1, 1'b1, base + 32'(k), 32'(k + 1)}) begin
        n_err++;
        $display("FAIL burst_beat%0d got s=%b we=%b a=%h d=%h want a=%h d=%h",
                 k, stall, wom_we, wom_addr, wom_wdata, base + 32'(k), k + 1);
      end
      tick();
    end
    n_vec++;
    if ({stall, wom_we} !== 2'b00) begin
      n_err++;
      $display("FAIL burst_end got s=%b we=%b want 0 0", stall, wom_we);
    end
  endtask

  task automatic test_ready_gap();
    int stall_cnt = 0;
    int held_cnt  = 0;
    int b;
    wr_wom_in = 1'b1; wr_mul_pos_in = 1'b1; wom_addr_in = 32'h200;
    r1_in = 32'd1; r2_in = 32'd2; r3_in = 32'd3; r4_in = 32'd4;
    wom_ready = 1'b1;
    tick();
    wr_wom_in = 1'b0;
    for (int c = 0; c < 20 && stall; c++) begin
      stall_cnt++;
      b = (c < 2) ? c : (c <= 5) ? 2 : c - 3;
      wom_ready = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
      if (wom_addr === 32'h202 && wom_wdata === 32'd3) held_cnt++;
      n_vec++;
      if ({wom_addr, wom_wdata} !== {32'h200 + 32'(b), 32'(b + 1)}) begin
        n_err++;
        $display("FAIL gap_cycle%0d got a=%h d=%h want a=%h d=%h",
                 c, wom_addr, wom_wdata, 32'h200 + 32'(b), b + 1);
      end
      tick();
    end
    wom_ready = 1'b1;
    n_vec++;
    if (stall_cnt != 7) begin
      n_err++;
      $display("FAIL gap_stall_len got %0d want 7", stall_cnt);
    end
    n_vec++;
    if (held_cnt != 4) begin
      n_err++;
      $display("FAIL gap_hold_len got %0d want 4", held_cnt);
    end
  endtask

  task automatic test_wrap();
    test_burst(32'hFFFF_FFFE);
  endtask

  task automatic test_reset_mid();
    wr_wom_in = 1'b1; wr_mul_pos_in = 1'b1; wom_addr_in = 32'h300;
    r1_in = $urandom; r2_in = 32'h1234_5678; r3_in = $urandom; r4_in = $urandom;
    wom_ready = 1'b1;
    tick();
    wr_wom_in = 1'b0;
    tick();
    n_vec++;
    if ({wom_addr, wom_wdata} !== {32'h301, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL rmid_beat1 got a=%h d=%h want a=301 d=12345678", wom_addr, wom_wdata);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({stall, wom_we, wom_addr, wom_wdata, wr_pxl_out, wr_pos_out, wr_mul_reg_out,
         i_out, r4_out} !== '0) begin
      n_err++;
      $display("FAIL rmid_async got s=%b we=%b a=%h d=%h want 0",
               stall, wom_we, wom_addr, wom_wdata);
    end
    model_reset();
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if ({stall, wom_we} !== 2'b00) begin
        n_err++;
        $display("FAIL rmid_after%0d got s=%b we=%b want 0 0", c, stall, wom_we);
      end
    end
  endtask

  task automatic test_writeback();
    wr_pxl_in = 1'b1; i_in = 32'd5; wr_wom_in = 1'b0; wom_ready = 1'b1;
    tick();
    n_vec++;
    if ({wr_pxl_out, i_out, stall} !== {1'b1, 32'd5, 1'b0}) begin
      n_err++;
      $display("FAIL wb_plain got p=%b i=%h s=%b want p=1 i=5 s=0", wr_pxl_out, i_out, stall);
    end
    wr_wom_in = 1'b1; wr_mul_pos_in = 1'b0; i_in = 32'd7; wom_ready = 1'b0;
    tick();
    wr_wom_in = 1'b0; i_in = 32'd9;
    n_vec++;
    if ({wr_pxl_out, i_out, stall} !== {1'b1, 32'd7, 1'b1}) begin
      n_err++;
      $display("FAIL wb_capture got p=%b i=%h s=%b want p=1 i=7 s=1", wr_pxl_out, i_out, stall);
    end
    tick();
    n_vec++;
    if ({wr_pxl_out, i_out, stall} !== {1'b0, 32'd7, 1'b1}) begin
      n_err++;
      $display("FAIL wb_bubble got p=%b i=%h s=%b want p=0 i=7 s=1", wr_pxl_out, i_out, stall);
    end
    wom_ready = 1'b1;
    tick();
    n_vec++;
    if ({wr_pxl_out, i_out, stall} !== {1'b0, 32'd7, 1'b0}) begin
      n_err++;
      $display("FAIL wb_last got p=%b i=%h s=%b want p=0 i=7 s=0", wr_pxl_out, i_out, stall);
    end
    tick();
    n_vec++;
    if ({wr_pxl_out, i_out, stall} !== {1'b1, 32'd9, 1'b0}) begin
      n_err++;
      $display("FAIL wb_held_instr got p=%b i=%h s=%b want p=1 i=9 s=0", wr_pxl_out, i_out, stall);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!exp_busy()) begin
        {wr_pxl_in, wr_pos_in, wr_mul_reg_in} = 3'($urandom);
        wr_wom_in     = ($urandom_range(0, 9) < 4);
        wr_mul_pos_in = 1'($urandom);
        wom_addr_in   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                    : $urandom;
        i_in = $urandom; j_in = $urandom; n_in = $urandom;
        r1_in = $urandom; r2_in = $urandom; r3_in = $urandom; r4_in = $urandom;
      end
      wom_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_vec++;
      if ({stall, wom_we, wom_addr, wom_wdata} !==
          {exp_busy(), exp_busy(), exp_addr(), exp_data()}) begin
        n_err++;
        $display("FAIL rand_wom c=%0d got s=%b we=%b a=%h d=%h want s=%b a=%h d=%h",
                 c, stall, wom_we, wom_addr, wom_wdata, exp_busy(), exp_addr(), exp_data());
      end
      n_vec++;
      if ({wr_pxl_out, wr_pos_out, wr_mul_reg_out} !== e_flags) begin
        n_err++;
        $display("FAIL rand_wb_flags c=%0d got %b want %b",
                 c, {wr_pxl_out, wr_pos_out, wr_mul_reg_out}, e_flags);
      end
      n_vec++;
      if ({i_out, j_out, n_out, r1_out, r2_out, r3_out, r4_out} !== e_data) begin
        n_err++;
        $display("FAIL rand_wb_data c=%0d got %h want %h",
                 c, {i_out, j_out, n_out, r1_out, r2_out, r3_out, r4_out}, e_data);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst(32'h200);
    test_ready_gap();
    test_wrap();
    test_reset_mid();
    test_writeback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
